// File: rtl/jtag_ir_dr_if.sv
// Bundle of TAP strobes, serial data and parallel user-register signals for jtag_ir_dr.
// master = TAP/controller side, slave = register bank.
interface jtag_ir_dr_if #(
    parameter int IR_W = 4,
    parameter int DR_W = 32
);
    logic            TDI;
    logic            CAPTUREIR;
    logic            SHIFTIR;
    logic            UPDATEIR;
    logic            CAPTUREDR;
    logic            SHIFTDR;
    logic            UPDATEDR;
    logic            TAP_RST;
    logic            SELECT;
    logic [DR_W-1:0] USER_DIN;
    logic            TDO;
    logic            TDO_EN;
    logic [IR_W-1:0] IR_VALUE;
    logic [DR_W-1:0] USER_DOUT;
    logic            USER_UPDATE;

    modport master (
        output TDI, CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR, SHIFTDR, UPDATEDR,
               TAP_RST, SELECT, USER_DIN,
        input  TDO, TDO_EN, IR_VALUE, USER_DOUT, USER_UPDATE
    );

    modport slave (
        input  TDI, CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR, SHIFTDR, UPDATEDR,
               TAP_RST, SELECT, USER_DIN,
        output TDO, TDO_EN, IR_VALUE, USER_DOUT, USER_UPDATE
    );
endinterface

// File: rtl/jtag_ir_dr.sv
// JTAG IR/DR register bank: 4-bit IR, BYPASS, IDCODE and user DR, TDO retimed on falling TCK.
// Optional macro JTAG_USER_LOOPBACK_EN adds USER_LOOP (4'b1001) readback of USER_DOUT.
module jtag_ir_dr #(
    parameter int          IR_W       = 4,
    parameter int          DR_W       = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic        TCK,
    input  logic        TRST_N,
    jtag_ir_dr_if.slave bus
);

    localparam logic [IR_W-1:0] OP_IDCODE    = 4'b0010;
    localparam logic [IR_W-1:0] OP_USER      = 4'b1000;
`ifdef JTAG_USER_LOOPBACK_EN
    localparam logic [IR_W-1:0] OP_USER_LOOP = 4'b1001;
`endif

    logic [IR_W-1:0] ir_value;
    logic [IR_W-1:0] ir_shift;
    logic            bypass;
    logic [31:0]     id_shift;
    logic [DR_W-1:0] user_shift;
    logic [DR_W-1:0] user_dout;
    logic            user_update;
    logic            tdo;
    logic            tdo_en;

    logic            sel_id;
    logic            sel_user;
    logic            sel_loop;
    logic [DR_W-1:0] user_cap_val;
    logic            dr_tdo;
    logic            capture_any;
    logic            shift_any;
    logic            do_shift_ir;
    logic            do_shift_dr;
    logic            do_upd_ir;
    logic            do_upd_dr;

    // Unknown opcodes fall through to BYPASS because neither sel_id nor sel_user is set.
    always_comb begin
        sel_id       = (ir_value == OP_IDCODE);
        sel_loop     = 1'b0;
        user_cap_val = bus.USER_DIN;
`ifdef JTAG_USER_LOOPBACK_EN
        sel_loop     = (ir_value == OP_USER_LOOP);
        if (sel_loop) user_cap_val = user_dout;
`endif
        sel_user     = (ir_value == OP_USER) || sel_loop;
        dr_tdo       = sel_id ? id_shift[0] : (sel_user ? user_shift[0] : bypass);

        capture_any  = bus.CAPTUREIR | bus.CAPTUREDR;
        shift_any    = bus.SHIFTIR | bus.SHIFTDR;
        do_shift_ir  = bus.SHIFTIR & ~capture_any;
        do_shift_dr  = bus.SHIFTDR & ~capture_any;
        do_upd_ir    = bus.UPDATEIR & ~capture_any & ~shift_any;
        do_upd_dr    = bus.UPDATEDR & ~capture_any & ~shift_any;
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_value <= OP_IDCODE;
            ir_shift <= '0;
        end else begin
            if (bus.CAPTUREIR)
                ir_shift <= IR_W'(1);
            else if (do_shift_ir)
                ir_shift <= {bus.TDI, ir_shift[IR_W-1:1]};

            if (!bus.TAP_RST)
                ir_value <= OP_IDCODE;
            else if (do_upd_ir)
                ir_value <= ir_shift;
        end
    end

    // Only the register selected by the current IR moves; the others keep their contents.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bypass      <= 1'b0;
            id_shift    <= '0;
            user_shift  <= '0;
            user_dout   <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (bus.CAPTUREDR) begin
                if (sel_id)
                    id_shift <= IDCODE_VAL;
                else if (sel_user)
                    user_shift <= user_cap_val;
                else
                    bypass <= 1'b0;
            end else if (do_shift_dr) begin
                if (sel_id)
                    id_shift <= {bus.TDI, id_shift[31:1]};
                else if (sel_user)
                    user_shift <= {bus.TDI, user_shift[DR_W-1:1]};
                else
                    bypass <= bus.TDI;
            end else if (do_upd_dr && sel_user && !sel_loop) begin
                user_dout   <= user_shift;
                user_update <= 1'b1;
            end
        end
    end

    // TDO is launched on the falling edge so the TAP's rising-edge sample sees a stable bit.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo    <= bus.SELECT ? ir_shift[0] : dr_tdo;
            tdo_en <= bus.SHIFTIR | bus.SHIFTDR;
        end
    end

    assign bus.TDO         = tdo;
    assign bus.TDO_EN      = tdo_en;
    assign bus.IR_VALUE    = ir_value;
    assign bus.USER_DOUT   = user_dout;
    assign bus.USER_UPDATE = user_update;

endmodule

// File: doc/jtag_ir_dr.md
Name: jtag_ir_dr

Overview:
- Instruction/data register bank downstream of the TAP controller; consumes its CAPTURE/SHIFT/UPDATE strobes, TAP_RST and SELECT.
- Holds a 4-bit instruction register, a 1-bit BYPASS register, a 32-bit IDCODE register and a DR_W-bit user data register.
- The user data register has a parallel capture input and a parallel update output with a one-cycle update strobe.
- Muxes the selected chain onto TDO and retimes TDO on the falling edge of TCK.

Parameters:
IR_W, 4, instruction register width (fixed at 4 for the opcode map below)
DR_W, 32, user data register width, 2..64
IDCODE_VAL, 32'h1000_0001, value captured by IDCODE; bit0 must be 1

Ports:
TCK  in  1  JTAG test clock; all state on rising edge except TDO/TDO_EN
TRST_N  in  1  asynchronous active-low reset
TDI  in  1  serial data in
CAPTUREIR  in  1  TAP capture-IR strobe
SHIFTIR  in  1  TAP shift-IR strobe
UPDATEIR  in  1  TAP update-IR strobe
CAPTUREDR  in  1  TAP capture-DR strobe
SHIFTDR  in  1  TAP shift-DR strobe
UPDATEDR  in  1  TAP update-DR strobe
TAP_RST  in  1  low while TAP is in Test-Logic-Reset
SELECT  in  1  1 = IR path drives TDO, 0 = DR path
USER_DIN  in  DR_W  parallel value captured into the user DR
TDO  out  1  serial data out
TDO_EN  out  1  output enable for the TDO pad
IR_VALUE  out  IR_W  current (updated) instruction
USER_DOUT  out  DR_W  last updated user DR value
USER_UPDATE  out  1  one-TCK pulse when USER_DOUT is loaded

Behaviour:
- Opcodes:
  - IDCODE = 4'b0010
  - USER = 4'b1000
  - BYPASS = 4'b1111
  - any other opcode selects BYPASS
- Reset (TRST_N low, asynchronous):
  - IR_VALUE = IDCODE; ir_shift = 0; bypass = 0; id_shift = 0; user_shift = 0
  - USER_DOUT = 0; USER_UPDATE = 0; TDO = 0; TDO_EN = 0
- TAP_RST sampled low at rising TCK: IR_VALUE <= IDCODE (synchronous); USER_DOUT holds its value.
- Strobe priority per rising edge: capture > shift > update; the TAP asserts at most one strobe at a time.
- IR path:
  - CAPTUREIR: ir_shift <= 4'b0001.
  - SHIFTIR: ir_shift <= {TDI, ir_shift[3:1]}.
  - UPDATEIR: IR_VALUE <= ir_shift.
- DR path, acting only on the register selected by IR_VALUE:
  - BYPASS: capture loads 0; shift loads TDI.
  - IDCODE: capture loads IDCODE_VAL; shift is LSB-first, right shift with TDI entering bit31; update has no effect.
  - USER: capture loads USER_DIN; shift is right shift with TDI entering bit DR_W-1; update does USER_DOUT <= user_shift and USER_UPDATE = 1 for exactly one TCK cycle.
- IR change: non-selected DR shift registers keep their contents across IR changes.
- TDO on falling TCK:
  - TDO <= SELECT ? ir_shift[0] : selected DR bit0 (bypass bit for BYPASS).
  - TDO_EN <= SHIFTIR | SHIFTDR.
  - Both change only on falling edges.
- Latency:
  - The first captured bit appears on TDO at the falling edge after the capture rising edge.
  - N bits shifted need N rising edges in SHIFT.
- Shift length:
  - Shifting more than the register length shifts TDI through; the last W bits win on update.
  - Zero shift cycles followed by update loads the captured value (USER: USER_DOUT <= USER_DIN).
- Reset mid-shift (TRST_N low): all state returns to reset values immediately; a pending update is lost.

Optional Feature:
- Macro: JTAG_USER_LOOPBACK_EN
- Defined:
  - Adds opcode USER_LOOP = 4'b1001, which selects the user DR.
  - Capture loads USER_DOUT instead of USER_DIN, giving readback of the last write.
  - Update does not change USER_DOUT and no USER_UPDATE pulse is generated.
- Not defined: 4'b1001 decodes as BYPASS.

Test Plan:
- Release TRST_N, Capture-DR, shift 32 bits with TDI=0 -> TDO stream equals 32'h1000_0001, LSB first; IR_VALUE = 4'b0010.
- Capture-IR, shift 4 bits with TDI=1 -> TDO stream 1,0,0,0; after update IR_VALUE = 4'b1111; a DR scan then returns first bit 0 followed by TDI delayed by one cycle.
- Load IR = 4'b1000, USER_DIN = 32'hA5A5_0F0F, shift in 32'hDEAD_BEEF -> TDO outputs 32'hA5A5_0F0F; after update USER_DOUT = 32'hDEAD_BEEF with USER_UPDATE high for 1 cycle.
- Load IR = 4'b0110 (undefined) -> behaves as BYPASS, 1-bit delay; USER_DOUT unchanged.
- Assert TRST_N low mid USER shift (after 10 bits), then release -> IR_VALUE = IDCODE, USER_DOUT = 0, TDO = 0, TDO_EN = 0, no USER_UPDATE.
- With JTAG_USER_LOOPBACK_EN defined: after the write of 32'hDEAD_BEEF, IR = 4'b1001 DR scan -> TDO outputs 32'hDEAD_BEEF, no USER_UPDATE pulse; without the macro the same scan behaves as BYPASS.
